// File: rtl/udp_ipv4_tx_if.sv
// udp_ipv4_tx_if: application payload and mac_tx stream signals of the UDP/IPv4 transmitter
interface udp_ipv4_tx_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W = $clog2(DATA_W/8)
);
    logic              app_start_i;
    logic [15:0]       app_plen_i;
    logic              app_valid_i;
    logic              app_ready_o;
    logic [DATA_W-1:0] app_data_i;
    logic              app_cancel_i;
    logic              err_o;
    logic              mac_valid_o;
    logic              mac_ready_i;
    logic [DATA_W-1:0] mac_data_o;
    logic              mac_first_o;
    logic              mac_last_o;
    logic [LEN_W-1:0]  mac_len_o;
    logic              mac_cancel_o;
    modport slave (
        input  app_start_i, app_plen_i, app_valid_i, app_data_i, app_cancel_i, mac_ready_i,
        output app_ready_o, err_o, mac_valid_o, mac_data_o, mac_first_o, mac_last_o, mac_len_o, mac_cancel_o
    );
    modport master (
        output app_start_i, app_plen_i, app_valid_i, app_data_i, app_cancel_i, mac_ready_i,
        input  app_ready_o, err_o, mac_valid_o, mac_data_o, mac_first_o, mac_last_o, mac_len_o, mac_cancel_o
    );
endinterface

// File: rtl/udp_ipv4_tx.sv
// udp_ipv4_tx: prepends IPv4 (with checksum) and UDP headers to an application payload stream
module udp_ipv4_tx #(
    parameter int          DATA_W   = 16,
    parameter int          KEEP_W   = DATA_W/8,
    parameter int          LEN_W    = $clog2(KEEP_W),
    parameter logic [31:0] SRC_IP   = 32'hC0A80102,
    parameter logic [31:0] DST_IP   = 32'hC0A80101,
    parameter logic [15:0] SRC_PORT = 16'd1234,
    parameter logic [15:0] DST_PORT = 16'd5678,
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [15:0] MAX_LEN  = 16'd1472
) (
    input logic          clk,
    input logic          reset,
    udp_ipv4_tx_if.slave bus
);
    if (DATA_W != 16) begin : g_bad_width
        $error("udp_ipv4_tx supports DATA_W=16 only");
    end
    typedef enum logic [1:0] {IDLE, CSUM, HDR, PAYLOAD} state_t;
    state_t      state;
    logic [15:0] plen, id, fid, csum, beats, fold;
    logic [3:0]  widx;
    logic [15:0] hdr [14];
    logic [19:0] sum;
    logic [16:0] s1;
    logic        adv, take;
    assign adv = !bus.mac_valid_o || bus.mac_ready_i;
    assign take = bus.app_valid_i && bus.app_ready_o;
    assign bus.app_ready_o = (state == PAYLOAD) && adv;
    // id has already advanced past the frame being built
    assign fid = id - 16'd1;
    assign sum = 20'h4500 + 20'(plen + 16'd28) + 20'(fid) + 20'h4000 + 20'({TTL, 8'd17})
               + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0]) + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    assign s1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    assign fold = s1[15:0] + 16'(s1[16]);
    always_comb begin
        hdr[0]  = 16'h4500;
        hdr[1]  = plen + 16'd28;
        hdr[2]  = fid;
        hdr[3]  = 16'h4000;
        hdr[4]  = {TTL, 8'd17};
        hdr[5]  = csum;
        hdr[6]  = SRC_IP[31:16];
        hdr[7]  = SRC_IP[15:0];
        hdr[8]  = DST_IP[31:16];
        hdr[9]  = DST_IP[15:0];
        hdr[10] = SRC_PORT;
        hdr[11] = DST_PORT;
        hdr[12] = plen + 16'd8;
        hdr[13] = 16'h0000;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            plen <= '0;
            id <= '0;
            csum <= '0;
            beats <= '0;
            widx <= '0;
            bus.err_o <= 1'b0;
            bus.mac_valid_o <= 1'b0;
            bus.mac_data_o <= '0;
            bus.mac_first_o <= 1'b0;
            bus.mac_last_o <= 1'b0;
            bus.mac_len_o <= '0;
            bus.mac_cancel_o <= 1'b0;
        end else begin
            bus.err_o <= 1'b0;
            bus.mac_cancel_o <= 1'b0;
            if (adv) bus.mac_valid_o <= 1'b0;
            if (state != IDLE && bus.app_cancel_i) begin
                state <= IDLE;
                bus.mac_valid_o <= 1'b0;
                bus.mac_cancel_o <= 1'b0 | 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.app_start_i) begin
                        if (bus.app_plen_i != 16'd0 && bus.app_plen_i <= MAX_LEN) begin
                            plen <= bus.app_plen_i;
                            beats <= (bus.app_plen_i + 16'd1) >> 1;
                            id <= id + 16'd1;
                            widx <= '0;
                            state <= CSUM;
                        end else bus.err_o <= 1'b1;
                    end
                    CSUM: begin
                        csum <= ~fold;
                        state <= HDR;
                    end
                    HDR: if (adv) begin
                        bus.mac_valid_o <= 1'b1;
                        bus.mac_data_o <= {hdr[widx][7:0], hdr[widx][15:8]};
                        bus.mac_first_o <= widx == 4'd0;
                        bus.mac_last_o <= 1'b0;
                        bus.mac_len_o <= '0;
                        widx <= widx + 4'd1;
                        if (widx == 4'd13) state <= PAYLOAD;
                    end
                    PAYLOAD: if (take) begin
                        bus.mac_valid_o <= 1'b1;
                        bus.mac_data_o <= bus.app_data_i;
                        bus.mac_first_o <= 1'b0;
                        bus.mac_last_o <= beats == 16'd1;
                        bus.mac_len_o <= beats == 16'd1 ? LEN_W'(plen[0]) : '0;
                        beats <= beats - 16'd1;
                        if (beats == 16'd1) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_udp_ipv4_tx.sv
// tb_udp_ipv4_tx: randomized frames checked against a header/payload reference model
module tb_udp_ipv4_tx;
    localparam logic [31:0] SRC_IP = 32'hC0A80102;
    localparam logic [31:0] DST_IP = 32'hC0A80101;
    localparam logic [15:0] SRC_PORT = 16'd1234;
    localparam logic [15:0] DST_PORT = 16'd5678;
    localparam logic [7:0]  TTL = 8'd64;
    typedef struct packed {logic [15:0] d; logic f; logic l; logic n;} beat_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    beat_t got[$], exp_q[$], held;
    logic [15:0] pay[$];
    logic [15:0] exp_id = 16'd0;
    int checks = 0, errors = 0, hold_bad = 0, fbase = 0;
    bit rand_ready = 1'b0, held_v = 1'b0;
    always #5 clk = ~clk;
    udp_ipv4_tx_if bus ();
    udp_ipv4_tx dut (.clk(clk), .reset(reset), .bus(bus));
    initial begin
        bus.mac_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.mac_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end
    always @(negedge clk) begin
        beat_t cur;
        cur = {bus.mac_data_o, bus.mac_first_o, bus.mac_last_o, bus.mac_len_o[0]};
        if (reset) held_v = 1'b0;
        else begin
            if (held_v && !bus.mac_cancel_o && !(bus.mac_valid_o && cur === held)) hold_bad++;
            if (bus.mac_valid_o && bus.mac_ready_i) got.push_back(cur);
            held_v = bus.mac_valid_o && !bus.mac_ready_i;
            held = cur;
        end
    end
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask
    function automatic logic [15:0] sw(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction
    task automatic build(input int plen, input logic [15:0] id);
        logic [15:0] w[14];
        int s, nb;
        w = '{16'h4500, 16'(plen + 28), id, 16'h4000, {TTL, 8'd17}, 16'h0000,
              SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0],
              SRC_PORT, DST_PORT, 16'(plen + 8), 16'h0000};
        s = 0;
        for (int i = 0; i < 10; i++) begin
            s += int'(w[i]);
            if (s > 65535) s = s - 65535;
        end
        w[5] = ~16'(s);
        exp_q.delete();
        for (int i = 0; i < 14; i++) exp_q.push_back({sw(w[i]), i == 0, 1'b0, 1'b0});
        nb = pay.size();
        for (int i = 0; i < nb; i++)
            exp_q.push_back({pay[i], 1'b0, i == nb - 1, i == nb - 1 ? 1'(plen % 2) : 1'b0});
    endtask
    task automatic run(input int plen, input int cancel_beat);
        int nb, t, hb;
        nb = (plen + 1) / 2;
        pay.delete();
        for (int i = 0; i < nb; i++) pay.push_back(16'($urandom));
        build(plen, exp_id);
        fbase = got.size();
        hb = hold_bad;
        bus.app_start_i = 1'b1;
        bus.app_plen_i = 16'(plen);
        @(posedge clk);
        #1;
        bus.app_start_i = 1'b0;
        exp_id++;
        for (int i = 0; i < nb; i++) begin
            if (i == cancel_beat) begin
                bus.app_cancel_i = 1'b1;
                @(posedge clk);
                #1;
                bus.app_cancel_i = 1'b0;
                @(negedge clk);
                chk("cancel_pulse", bus.mac_cancel_o, 1);
                chk("cancel_valid", bus.mac_valid_o, 0);
                chk("cancel_ready", bus.app_ready_o, 0);
                @(negedge clk);
                chk("cancel_once", bus.mac_cancel_o, 0);
                @(posedge clk);
                #1;
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            bus.app_valid_i = 1'b1;
            bus.app_data_i = pay[i];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.app_ready_o && t < 3000);
            chk("accept_in_time", 32'(t < 3000), 1);
            @(posedge clk);
            #1;
            bus.app_valid_i = 1'b0;
        end
        t = 0;
        while (got.size() - fbase < exp_q.size() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("beat_count", got.size() - fbase, exp_q.size());
        for (int i = 0; i < exp_q.size() && fbase + i < got.size(); i++) begin
            chk($sformatf("data[%0d]", i), got[fbase + i].d, exp_q[i].d);
            chk($sformatf("first[%0d]", i), got[fbase + i].f, exp_q[i].f);
            chk($sformatf("last[%0d]", i), got[fbase + i].l, exp_q[i].l);
            if (exp_q[i].l) chk("len_last", got[fbase + i].n, exp_q[i].n);
        end
        chk("hold_stable", hold_bad - hb, 0);
        @(posedge clk);
        #1;
    endtask
    task automatic bad(input int plen);
        bus.app_start_i = 1'b1;
        bus.app_plen_i = 16'(plen);
        @(posedge clk);
        #1;
        bus.app_start_i = 1'b0;
        @(negedge clk);
        chk("err_pulse", bus.err_o, 1);
        chk("err_no_valid", bus.mac_valid_o, 0);
        @(negedge clk);
        chk("err_once", bus.err_o, 0);
        chk("err_no_valid2", bus.mac_valid_o, 0);
        @(posedge clk);
        #1;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus.mac_valid_o, 0);
        chk({tag, "_data"}, bus.mac_data_o, 0);
        chk({tag, "_first"}, bus.mac_first_o, 0);
        chk({tag, "_last"}, bus.mac_last_o, 0);
        chk({tag, "_len"}, bus.mac_len_o, 0);
        chk({tag, "_cancel"}, bus.mac_cancel_o, 0);
        chk({tag, "_err"}, bus.err_o, 0);
        chk({tag, "_ready"}, bus.app_ready_o, 0);
    endtask
    initial begin
        int t;
        bus.app_start_i = 1'b0;
        bus.app_plen_i = 16'd0;
        bus.app_valid_i = 1'b0;
        bus.app_data_i = 16'd0;
        bus.app_cancel_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(18, -1);
        chk("w1_len46", got[fbase + 1].d, 16'h2E00);
        chk("w5_csum", got[fbase + 5].d, 16'h6BB7);
        chk("w12_udplen", got[fbase + 12].d, 16'h1A00);
        chk("len18_last", got[fbase + 22].n, 0);
        run(1, -1);
        chk("w1_len29", got[fbase + 1].d, 16'h1D00);
        chk("w2_id1", got[fbase + 2].d, 16'h0100);
        chk("p1_last", got[fbase + 14].l, 1);
        chk("p1_len", got[fbase + 14].n, 1);
        bad(0);
        bad(1473);
        run(4, -1);
        chk("w2_id2", got[fbase + 2].d, 16'h0200);
        rand_ready = 1'b1;
        run(18, -1);
        for (int i = 0; i < 4; i++) run($urandom_range(1, 60), -1);
        run(1472, -1);
        rand_ready = 1'b0;
        run(18, 2);
        run(6, -1);
        bus.app_start_i = 1'b1;
        bus.app_plen_i = 16'd18;
        @(posedge clk);
        #1;
        bus.app_start_i = 1'b0;
        t = 0;
        while (!(bus.mac_valid_o && bus.mac_data_o === 16'h0201) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("hdr_w7_seen", 32'(t < 100), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midreset");
        reset = 1'b0;
        exp_id = 16'd0;
        run(10, -1);
        chk("w2_id0_after_reset", got[fbase + 2].d, 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
